// File: rtl/pq_arbiter.sv
// Round-robin front end for a shared heap priority queue: issues one
// command strobe per grant, then holds off for a settle window.
module pq_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 16,
  parameter int ISSUE_GAP  = 8
) (
  input  logic                          CLK,
  input  logic                          RST,
  input  logic [NUM_REQ-1:0]            i_req_valid,
  input  logic [2*NUM_REQ-1:0]          i_req_op,
  input  logic [DATA_WIDTH*NUM_REQ-1:0] i_req_data,
  output logic [NUM_REQ-1:0]            o_req_ready,
  output logic                          o_rsp_valid,
  output logic [$clog2(NUM_REQ)-1:0]    o_rsp_id,
  output logic [DATA_WIDTH-1:0]         o_rsp_data,
  output logic                          o_rsp_err,
  output logic                          o_pq_wrt,
  output logic                          o_pq_read,
  output logic [DATA_WIDTH-1:0]         o_pq_data,
  input  logic                          i_pq_full,
  input  logic                          i_pq_empty,
  input  logic [DATA_WIDTH-1:0]         i_pq_data
);

  localparam int ID_W  = $clog2(NUM_REQ);
  localparam int CNT_W = (ISSUE_GAP > 1) ? $clog2(ISSUE_GAP) : 1;

  localparam logic [1:0] OP_ENQ = 2'b00;
  localparam logic [1:0] OP_DEQ = 2'b01;
  localparam logic [1:0] OP_REP = 2'b10;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ISSUE  = 2'd1,
    S_SETTLE = 2'd2
  } state_e;

  state_e                  state_q, state_d;
  logic [ID_W-1:0]         rr_ptr_q, rr_ptr_d;
  logic [ID_W-1:0]         id_q, id_d;
  logic [1:0]              op_q, op_d;
  logic [DATA_WIDTH-1:0]   key_q, key_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;

  logic                    found_s;
  logic [ID_W-1:0]         win_s;
  logic [ID_W-1:0]         idx_s;

  // Search from rr_ptr upward (mod NUM_REQ) for the first valid requester.
  always_comb begin
    found_s = 1'b0;
    win_s   = '0;
    idx_s   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx_s = ID_W'((int'(rr_ptr_q) + i) % NUM_REQ);
      if (!found_s && i_req_valid[idx_s]) begin
        found_s = 1'b1;
        win_s   = idx_s;
      end else begin
        found_s = found_s;
      end
    end
    if ((state_q == S_IDLE) && found_s) begin
      o_req_ready = NUM_REQ'(1) << win_s;
    end else begin
      o_req_ready = '0;
    end
  end

  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    id_d     = id_q;
    op_d     = op_q;
    key_d    = key_q;
    cnt_d    = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (found_s) begin
          id_d     = win_s;
          op_d     = i_req_op[2*int'(win_s) +: 2];
          key_d    = i_req_data[DATA_WIDTH*int'(win_s) +: DATA_WIDTH];
          rr_ptr_d = (win_s == ID_W'(NUM_REQ-1)) ? '0 : win_s + ID_W'(1);
          state_d  = S_ISSUE;
        end else begin
          state_d  = S_IDLE;
        end
      end
      S_ISSUE: begin
        cnt_d   = CNT_W'(ISSUE_GAP-1);
        state_d = S_SETTLE;
      end
      S_SETTLE: begin
        if (cnt_q == '0) begin
          state_d = S_IDLE;
        end else begin
          cnt_d   = cnt_q - CNT_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Command/response decode: latched op plus queue status seen in the ISSUE cycle.
  always_comb begin
    o_rsp_valid = 1'b0;
    o_rsp_id    = '0;
    o_rsp_data  = '0;
    o_rsp_err   = 1'b0;
    o_pq_wrt    = 1'b0;
    o_pq_read   = 1'b0;
    o_pq_data   = '0;
    if (state_q == S_ISSUE) begin
      o_rsp_valid = 1'b1;
      o_rsp_id    = id_q;
      case (op_q)
        OP_ENQ: begin
          if (i_pq_full) begin
            o_rsp_err = 1'b1;
          end else begin
            o_pq_wrt  = 1'b1;
            o_pq_data = key_q;
          end
        end
        OP_DEQ: begin
          if (i_pq_empty) begin
            o_rsp_err  = 1'b1;
          end else begin
            o_pq_read  = 1'b1;
            o_rsp_data = i_pq_data;
          end
        end
        OP_REP: begin
          o_pq_wrt  = 1'b1;
          o_pq_data = key_q;
          if (i_pq_empty) begin
            o_pq_read  = 1'b0;
          end else begin
            o_pq_read  = 1'b1;
            o_rsp_data = i_pq_data;
          end
        end
        default: o_rsp_err = 1'b1;
      endcase
    end else begin
      o_rsp_valid = 1'b0;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q  <= S_IDLE;
      rr_ptr_q <= '0;
      id_q     <= '0;
      op_q     <= 2'b00;
      key_q    <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      id_q     <= id_d;
      op_q     <= op_d;
      key_q    <= key_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule
